// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single outstanding access to a word-wide data memory,
// with byte-lane steering, load extension, misalignment and bus-timeout faults.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dm_valid,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        done,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        fault_misaligned,
  output logic        fault_bus,
  output logic        busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MISALIGN, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mis_q;
  logic               bus_q;
  logic               accept;
  logic               bad_req;
  logic               cnt_max;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_ext;

  assign cnt_max = (cnt_q == CNT_W'(TIMEOUT));

  // Illegal width codes and misaligned addresses share the no-access fault path
  always_comb begin
    bad_req = 1'b0;
    unique case (req_funct3)
      3'b000: bad_req = 1'b0;
      3'b001: bad_req = req_addr[0];
      3'b010: bad_req = (req_addr[1:0] != 2'b00);
      3'b100: bad_req = req_we;
      3'b101: bad_req = req_we | req_addr[0];
      default: bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    dm_valid  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        accept    = req_valid;
        if (req_valid) state_d = bad_req ? MISALIGN : ACCESS;
      end
      MISALIGN: state_d = DONE;
      ACCESS: begin
        dm_valid = 1'b1;
        if (dm_ready || cnt_max) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout counter, fault flags and writeback registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
      wb_data <= 32'h0;
      wb_rd   <= 5'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wb_rd   <= req_rd;
        cnt_q   <= '0;
        mis_q   <= 1'b0;
        bus_q   <= 1'b0;
      end
      if (state_q == MISALIGN) mis_q <= 1'b1;
      if (state_q == ACCESS) begin
        if (dm_ready) begin
          if (!we_q) wb_data <= load_ext;
        end else if (cnt_max) begin
          bus_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_we    = dm_valid & we_q;

  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        dm_be    = 4'b0001 << addr_q[1:0];
        dm_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{wdata_q[15:0]}};
      end
      default: dm_be = 4'b1111;
    endcase
    if (!dm_valid) dm_be = 4'b0000;
  end

  // Lane select then sign/zero extension of the returned word
  always_comb begin
    lane_b   = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_ext = dm_rdata;
    unique case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = dm_rdata;
    endcase
  end

  assign fault_misaligned = done & mis_q;
  assign fault_bus        = done & bus_q;
  assign wb_en            = done & ~we_q & ~mis_q & ~bus_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; inputs driven and outputs sampled on negedge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        resetb;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dm_valid, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        done, wb_en, fault_misaligned, fault_bus, busy;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dm_valid(dm_valid), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .done(done), .wb_en(wb_en), .wb_data(wb_data), .wb_rd(wb_rd),
    .fault_misaligned(fault_misaligned), .fault_bus(fault_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
  endtask

  task automatic test_reset();
    resetb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; dm_ready = 1'b0; dm_rdata = 32'h0;
    #1;
    checks++;
    if ({busy, req_ready, dm_valid, dm_we, dm_be, done, wb_en, fault_misaligned, fault_bus}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl got b%0b r%0b v%0b be%b d%0b", busy, req_ready, dm_valid, dm_be, done);
    end
    checks++;
    if ({wb_data, wb_rd} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL reset_wb got %h/%0d exp 0/0", wb_data, wb_rd);
    end
    @(negedge clk); @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lb();
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL lb_ready got %b exp 1", req_ready); end
    @(negedge clk); // N+1
    req_valid = 1'b0; dm_ready = 1'b1; dm_rdata = 32'h80FF_0000;
    checks++;
    if ({dm_valid, dm_we, dm_addr, dm_be, req_ready} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL lb_access got v%b w%b a%h be%b exp v1 w0 a00000100 be1000", dm_valid, dm_we, dm_addr, dm_be);
    end
    @(negedge clk); // N+2
    dm_ready = 1'b0;
    checks++;
    if ({done, wb_en, fault_misaligned, fault_bus, wb_data, wb_rd, dm_valid}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF80, 5'd5, 1'b0}) begin
      errors++; $display("FAIL lb_done got d%b en%b data %h rd %0d exp d1 en1 ffffff80 5", done, wb_en, wb_data, wb_rd);
    end
    @(negedge clk); // N+3
    checks++;
    if ({req_ready, done, wb_en, wb_data} !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL lb_idle got rdy%b d%b en%b data %h", req_ready, done, wb_en, wb_data);
    end
  endtask

  task automatic test_sh_wait();
    logic stable;
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd1);
    @(negedge clk); // N+1
    req_valid = 1'b0;
    checks++;
    if ({dm_valid, dm_we, dm_addr, dm_be, dm_wdata} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin
      errors++; $display("FAIL sh_access got v%b w%b a%h be%b wd%h", dm_valid, dm_we, dm_addr, dm_be, dm_wdata);
    end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({dm_valid, dm_we, dm_addr, dm_be, dm_wdata, done} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0})
        stable = 1'b0;
    end
    dm_ready = 1'b1;
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b exp 1", stable); end
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({done, wb_en, fault_misaligned, fault_bus, dm_valid} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sh_done got d%b en%b fm%b fb%b v%b exp d1 en0", done, wb_en, fault_misaligned, fault_bus, dm_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_sb();
    issue(1'b1, 3'b000, 32'h0000_0001, 32'hCAFE_0055, 5'd0);
    @(negedge clk);
    req_valid = 1'b0; dm_ready = 1'b1;
    checks++;
    if ({dm_be, dm_wdata, dm_we} !== {4'b0010, 32'h5555_5555, 1'b1}) begin
      errors++; $display("FAIL sb_lanes got be%b wd%h w%b exp be0010 wd55555555", dm_be, dm_wdata, dm_we);
    end
    @(negedge clk);
    dm_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'h0, 5'd3);
    @(negedge clk); // N+1
    req_valid = 1'b0;
    checks++;
    if ({dm_valid, busy, dm_be} !== {1'b0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL mis_noaccess f3=%b got v%b busy%b be%b exp v0 busy1", f3, dm_valid, busy, dm_be);
    end
    @(negedge clk); // N+2
    checks++;
    if ({done, fault_misaligned, fault_bus, wb_en} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mis_done f3=%b got d%b fm%b fb%b en%b exp 1100", f3, done, fault_misaligned, fault_bus, wb_en);
    end
    @(negedge clk);
    checks++;
    if ({fault_misaligned, req_ready} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL mis_after got fm%b rdy%b exp fm0 rdy1", fault_misaligned, req_ready);
    end
  endtask

  task automatic test_timeout();
    int vcnt;
    issue(1'b0, 3'b101, 32'h0000_0010, 32'h0, 5'd7);
    @(negedge clk);
    req_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20 && dm_valid === 1'b1; i++) begin
      vcnt++;
      @(negedge clk);
    end
    checks++;
    if (vcnt !== 16) begin errors++; $display("FAIL to_valid_cycles got %0d exp 16", vcnt); end
    checks++;
    if ({done, fault_bus, fault_misaligned, wb_en, dm_valid} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL to_fault got d%b fb%b fm%b en%b v%b exp 11000", done, fault_bus, fault_misaligned, wb_en, dm_valid);
    end
    @(negedge clk);
    // dm_ready arrives on the last permitted cycle
    issue(1'b0, 3'b101, 32'h0000_0010, 32'h0, 5'd8);
    @(negedge clk);
    req_valid = 1'b0; dm_rdata = 32'h1234_8001;
    for (int i = 0; i < 15; i++) @(negedge clk);
    dm_ready = 1'b1;
    checks++;
    if (dm_valid !== 1'b1) begin errors++; $display("FAIL to_edge_valid got %b exp 1", dm_valid); end
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({done, fault_bus, wb_en, wb_data, wb_rd} !== {1'b1, 1'b0, 1'b1, 32'h0000_8001, 5'd8}) begin
      errors++; $display("FAIL to_edge_done got d%b fb%b en%b data %h rd %0d exp 1 0 1 00008001 8", done, fault_bus, wb_en, wb_data, wb_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 5'd9);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({dm_valid, busy, req_ready, wb_rd} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL rst_mid got v%b busy%b rdy%b rd%0d exp v0 busy0 rdy1 rd0", dm_valid, busy, req_ready, wb_rd);
    end
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 5'd10);
    @(negedge clk);
    req_valid = 1'b0; dm_ready = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    checks++;
    if ({dm_valid, dm_be} !== {1'b1, 4'b1111}) begin
      errors++; $display("FAIL rst_next_access got v%b be%b exp v1 be1111", dm_valid, dm_be);
    end
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({done, wb_en, wb_data, wb_rd} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 5'd10}) begin
      errors++; $display("FAIL rst_next_done got d%b en%b data %h rd %0d exp 1 1 deadbeef 10", done, wb_en, wb_data, wb_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b100, 32'h0000_0001, 32'h0, 5'd11);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", req_ready); end
    @(negedge clk); // N+1, second request held
    issue(1'b0, 3'b100, 32'h0000_0002, 32'h0, 5'd12);
    dm_ready = 1'b1; dm_rdata = 32'h00C3_A500;
    checks++;
    if ({req_ready, dm_valid, dm_be} !== {1'b0, 1'b1, 4'b0010}) begin
      errors++; $display("FAIL b2b_access got rdy%b v%b be%b exp 0 1 0010", req_ready, dm_valid, dm_be);
    end
    @(negedge clk); // N+2
    checks++;
    if ({req_ready, done, wb_data, wb_rd} !== {1'b0, 1'b1, 32'h0000_00A5, 5'd11}) begin
      errors++; $display("FAIL b2b_done got rdy%b d%b data %h rd %0d exp 0 1 000000a5 11", req_ready, done, wb_data, wb_rd);
    end
    @(negedge clk); // N+3
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready got %b exp 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({dm_valid, dm_be} !== {1'b1, 4'b0100}) begin
      errors++; $display("FAIL b2b_second_access got v%b be%b exp 1 0100", dm_valid, dm_be);
    end
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({done, wb_data, wb_rd} !== {1'b1, 32'h0000_00C3, 5'd12}) begin
      errors++; $display("FAIL b2b_second_done got d%b data %h rd %0d exp 1 000000c3 12", done, wb_data, wb_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_wait();
    test_sb();
    test_misalign(1'b0, 3'b010, 32'h0000_0006);
    test_misalign(1'b1, 3'b100, 32'h0000_0000);
    test_misalign(1'b0, 3'b011, 32'h0000_0000);
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles dm_valid may wait for dm_ready before a bus fault is reported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetb  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  pipeline presents a load/store.
REQ-005 req_ready  output  1  request accepted this cycle (req_valid & req_ready).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010).
REQ-008 req_addr  input  32  effective byte address.
REQ-009 req_wdata  input  32  unshifted store operand (rs2).
REQ-010 req_rd  input  5  load destination register.
REQ-011 dm_valid, dm_we  output  1 each  memory request and write strobe.
REQ-012 dm_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-013 dm_be  output  4  byte enables; dm_wdata  output  32  lane-replicated store data.
REQ-014 dm_ready  input  1; dm_rdata  input  32  memory completion and read word.
REQ-015 done  output  1  one-cycle completion pulse; wb_en  output  1  done & load & no fault.
REQ-016 wb_data  output  32  aligned, extended load result; wb_rd  output  5  captured req_rd.
REQ-017 fault_misaligned, fault_bus  output  1 each  valid only with done.
REQ-018 busy  output  1  state != IDLE.

Function
REQ-019 FSM states IDLE, MISALIGN, ACCESS, DONE; req_ready = (state == IDLE).
REQ-020 IDLE + accepted request: latch we, funct3, addr, wdata, rd; misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> MISALIGN, else -> ACCESS.
REQ-021 MISALIGN: no memory access; next cycle -> DONE with fault_misaligned=1.
REQ-022 ACCESS: dm_valid=1 with stable dm_addr/dm_we/dm_be/dm_wdata until the cycle dm_ready=1; on dm_ready, capture dm_rdata -> DONE.
REQ-023 Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle with dm_ready=0; when it equals TIMEOUT and dm_ready=0 -> DONE with fault_bus=1, dm_valid drops.
REQ-024 dm_ready=1 in the same cycle the counter reaches TIMEOUT counts as success, not fault.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE unconditionally; no new request accepted in DONE.
REQ-026 Minimum latency with zero-wait memory: accept cycle N, dm_valid N+1, done N+2, req_ready again N+3.
REQ-027 dm_be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
REQ-028 dm_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 Load extract: byte = dm_rdata[8*addr[1:0]+:8], half = addr[1]?[31:16]:[15:0]; sign-extend for 000/001, zero-extend for 100/101; word unchanged.
REQ-030 Undefined req_funct3 (011, 110, 111, or 1xx with store) -> treated as misaligned path, fault_misaligned=1, no memory access.
REQ-031 wb_data, wb_rd held stable from DONE until next accepted request.
REQ-032 fault flags and wb_en are 0 whenever done=0.

Reset
REQ-033 resetb low: state IDLE, counter 0, dm_valid=0, dm_we=0, dm_be=0, done=0, wb_en=0, faults=0, busy=0, wb_data=0, wb_rd=0, effective immediately without clk.
REQ-034 Reset during ACCESS abandons the transfer; dm_valid deasserts asynchronously; first request after release accepted normally.

Verification
REQ-035 LB addr 0x103, dm_rdata 0x80FF_0000 zero-wait -> dm_addr 0x100, dm_be 1000, done at N+2, wb_en=1, wb_data 0xFFFF_FF80.
REQ-036 SH addr 0x202, wdata 0x1234_ABCD, dm_ready after 3 waits -> dm_be 1100, dm_wdata 0xABCD_ABCD, dm_we=1, done one cycle after dm_ready, wb_en=0.
REQ-037 LW addr 0x6 -> no dm_valid, done at N+2 with fault_misaligned=1, wb_en=0.
REQ-038 LHU addr 0x10, dm_ready never -> dm_valid high TIMEOUT+1 cycles, then done with fault_bus=1; dm_ready exactly at counter==TIMEOUT -> success.
REQ-039 resetb low mid-ACCESS -> dm_valid 0 immediately, busy 0; next LW addr 0x0 after release completes, wb_data = dm_rdata.
REQ-040 Back-to-back req_valid held high -> second request accepted only at N+3, req_ready=0 in ACCESS and DONE.
